io_pattern_tester: RTL

- Parametrised on-chip stimulus/response engine for TT-style user-project pads.
- Drives a WIDTH-bit pattern bus (ui_in/uio style) with generated patterns.
- Compares the returned bus against the expected pattern after a programmable loop latency, and counts mismatches.
- Successor to the fixed 8-bit project harness: generalised width, latency and pattern modes, with built-in self-checking instead of an external bench.

---
 rtl/io_tester_pkg.sv | 28 ++
 rtl/io_pattern_tester_pattern_gen.sv | 45 ++++
 rtl/io_pattern_tester.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/io_tester_pkg.sv
// Shared encodings for the pad stimulus/response tester.
// Pattern modes, FSM states and the default LFSR tap mask.
package io_tester_pkg;

    localparam logic [1:0] MODE_CNT  = 2'd0;
    localparam logic [1:0] MODE_WALK = 2'd1;
    localparam logic [1:0] MODE_LFSR = 2'd2;
    localparam logic [1:0] MODE_ALT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] LFSR_TAP_DEF = 32'hB8;

    // Latency of 0 behaves as 1; anything past the delay line depth is clamped.
    function automatic logic [3:0] clamp_lat(input logic [3:0] l,
                                             input int unsigned max_lat);
        if (l == 4'd0)
            return 4'd1;
        if (32'(l) > max_lat)
            return 4'(max_lat);
        return l;
    endfunction

endpackage

// File: rtl/io_pattern_tester_pattern_gen.sv
// Pattern generator: word for the current index and mode.
// Owns the LFSR state, reseeded to 1 at each burst launch.
module pattern_gen
    import io_tester_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter int          IDX_W = 8,
    parameter logic [31:0] TAP   = LFSR_TAP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reseed,
    input  logic             advance,
    input  logic [1:0]       mode,
    input  logic [IDX_W-1:0] index,
    output logic [WIDTH-1:0] word
);

    localparam logic [WIDTH-1:0] ALT_EVEN = WIDTH'({(WIDTH/2){2'b01}});
    localparam logic [WIDTH-1:0] TAP_W    = TAP[WIDTH-1:0];

    logic [WIDTH-1:0] lfsr;

    // Fibonacci LFSR stepping once per issued word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr <= WIDTH'(1);
        else if (reseed)
            lfsr <= WIDTH'(1);
        else if (advance)
            lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAP_W)};
    end

    // Select the generated word for the active mode.
    always_comb begin
        word = '0;
        unique case (1'b1)
            (mode == MODE_CNT):  word = WIDTH'(index);
            (mode == MODE_WALK): word = WIDTH'(1) << (32'(index) % WIDTH);
            (mode == MODE_LFSR): word = lfsr;
            (mode == MODE_ALT):  word = index[0] ? ~ALT_EVEN : ALT_EVEN;
        endcase
    end

endmodule

// File: rtl/io_pattern_tester.sv
// On-chip pad stimulus/response engine: issues a burst of patterns,
// checks the looped-back bus after a programmable latency, counts errors.
module io_pattern_tester
    import io_tester_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int          MAX_LAT  = 4,
    parameter int          LEN_W    = 8,
    parameter int          ERR_W    = 8,
    parameter logic [31:0] LFSR_TAP = LFSR_TAP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [3:0]       lat,
    input  logic [LEN_W-1:0] len,
    output logic [WIDTH-1:0] pat_out,
    output logic [WIDTH-1:0] pat_oe,
    input  logic [WIDTH-1:0] rsp_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [LEN_W-1:0] first_err
);

    state_t           state;
    logic [1:0]       mode_q;
    logic [3:0]       lat_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] issue_idx;
    logic [LEN_W-1:0] chk_idx;

    logic [WIDTH-1:0] dl_data [MAX_LAT];
    logic [MAX_LAT-1:0] dl_vld;

    logic [WIDTH-1:0] gen_word;
    logic [WIDTH-1:0] tap_data;
    logic             tap_vld;
    logic             launch;
    logic             running;
    logic             issuing;
    logic             chk;
    logic             mism;

    assign launch  = ena && start && (state != ST_RUN);
    assign running = ena && (state == ST_RUN);
    assign issuing = running && (issue_idx != len_q);
    assign chk     = running && tap_vld;
    assign mism    = chk && (rsp_in != tap_data);

    pattern_gen #(
        .WIDTH (WIDTH),
        .IDX_W (LEN_W),
        .TAP   (LFSR_TAP)
    ) u_gen (
        .clk     (clk),
        .rst     (rst),
        .reseed  (launch),
        .advance (issuing),
        .mode    (mode_q),
        .index   (issue_idx),
        .word    (gen_word)
    );

    // Pick the delay-line stage matching the loop latency.
    always_comb begin
        tap_vld  = 1'b0;
        tap_data = '0;
        for (int i = 0; i < MAX_LAT; i++) begin
            if (lat_q == 4'(i + 1)) begin
                tap_vld  = dl_vld[i];
                tap_data = dl_data[i];
            end
        end
    end

    // Expected-word delay line; advances only on enabled RUN cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_vld <= '0;
            for (int i = 0; i < MAX_LAT; i++)
                dl_data[i] <= '0;
        end else if (launch) begin
            dl_vld <= '0;
        end else if (running) begin
            dl_data[0] <= gen_word;
            dl_vld[0]  <= issuing;
            for (int i = 1; i < MAX_LAT; i++) begin
                dl_data[i] <= dl_data[i-1];
                dl_vld[i]  <= dl_vld[i-1];
            end
        end
    end

    // Burst FSM with issue, check and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_CNT;
            lat_q     <= 4'd1;
            len_q     <= '0;
            issue_idx <= '0;
            chk_idx   <= '0;
            pat_out   <= '0;
            pat_oe    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            first_err <= '1;
        end else if (ena) begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mode_q    <= mode;
                        lat_q     <= clamp_lat(lat, MAX_LAT);
                        len_q     <= len;
                        issue_idx <= '0;
                        chk_idx   <= '0;
                        err_count <= '0;
                        first_err <= '1;
                        if (len == '0) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            pass  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (chk_idx == len_q) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0);
                    end
                    if (issuing) begin
                        pat_out   <= gen_word;
                        pat_oe    <= '1;
                        issue_idx <= issue_idx + LEN_W'(1);
                    end else begin
                        pat_oe <= '0;
                    end
                    if (chk)
                        chk_idx <= chk_idx + LEN_W'(1);
                    if (mism) begin
                        if (err_count != '1)
                            err_count <= err_count + ERR_W'(1);
                        if (first_err == '1)
                            first_err <= chk_idx;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
